// File: rtl/addsub_share_pkg.sv
// Shared types for the two-requester add/sub/compare scheduler.
package addsub_share_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_CMP = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_e;

    // Everything except ADD runs the adder in subtract mode; reserved behaves as CMP.
    function automatic logic op_is_sub(input op_e op);
        return op != OP_ADD;
    endfunction

endpackage

// File: rtl/addsub_cmp_unit.sv
// Combinational adder-subtractor with unsigned magnitude compare.
module addsub_cmp_unit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o,
    output logic             eq_o,
    output logic             gt_o,
    output logic             lt_o
);

    logic [WIDTH:0] sum;

    // One adder: b is inverted and cin set for subtraction, so cout means no-borrow.
    assign sum = {1'b0, a_i} + {1'b0, b_i ^ {WIDTH{sub_i}}} + {{WIDTH{1'b0}}, sub_i};

    assign s_o    = sum[WIDTH-1:0];
    assign cout_o = sum[WIDTH];
    assign eq_o   = (a_i == b_i);
    assign gt_o   = (a_i > b_i);
    assign lt_o   = (a_i < b_i);

endmodule

// File: rtl/addsub_share_ctrl.sv
// Round-robin scheduler sharing one add/sub/compare unit between two requesters.
module addsub_share_ctrl
    import addsub_share_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_i,
    input  logic [1:0]       op0_i,
    input  logic [WIDTH-1:0] a0_i,
    input  logic [WIDTH-1:0] b0_i,
    output logic             gnt0_o,
    input  logic             req1_i,
    input  logic [1:0]       op1_i,
    input  logic [WIDTH-1:0] a1_i,
    input  logic [WIDTH-1:0] b1_i,
    output logic             gnt1_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             res_id_o,
    output logic [WIDTH-1:0] res_s_o,
    output logic             res_cout_o,
    output logic             res_eq_o,
    output logic             res_gt_o,
    output logic             res_lt_o
);

    state_e           state_q, state_d;
    logic             last_gnt_q, last_gnt_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             id_q, id_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d, eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

    logic             pick1;
    logic [WIDTH-1:0] unit_s;
    logic             unit_cout, unit_eq, unit_gt, unit_lt;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign pick1 = req1_i & (~req0_i | ~last_gnt_q);

    addsub_cmp_unit #(
        .WIDTH (WIDTH)
    ) u_unit (
        .a_i    (a_q),
        .b_i    (b_q),
        .sub_i  (op_is_sub(op_q)),
        .s_o    (unit_s),
        .cout_o (unit_cout),
        .eq_o   (unit_eq),
        .gt_o   (unit_gt),
        .lt_o   (unit_lt)
    );

    // Next-state: arbitration in IDLE, result capture in EXEC, handshake in RESP.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        valid_d    = valid_q;
        s_d        = s_q;
        cout_d     = cout_q;
        eq_d       = eq_q;
        gt_d       = gt_q;
        lt_d       = lt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req0_i || req1_i) begin
                    op_d       = pick1 ? op_e'(op1_i) : op_e'(op0_i);
                    a_d        = pick1 ? a1_i : a0_i;
                    b_d        = pick1 ? b1_i : b0_i;
                    id_d       = pick1;
                    last_gnt_d = pick1;
                    gnt0_d     = ~pick1;
                    gnt1_d     = pick1;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                valid_d = 1'b1;
                s_d     = unit_s;
                cout_d  = unit_cout;
                eq_d    = unit_eq;
                gt_d    = unit_gt;
                lt_d    = unit_lt;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (res_ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b1;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            valid_q    <= 1'b0;
            s_q        <= '0;
            cout_q     <= 1'b0;
            eq_q       <= 1'b0;
            gt_q       <= 1'b0;
            lt_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            id_q       <= id_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            valid_q    <= valid_d;
            s_q        <= s_d;
            cout_q     <= cout_d;
            eq_q       <= eq_d;
            gt_q       <= gt_d;
            lt_q       <= lt_d;
        end
    end

    assign gnt0_o      = gnt0_q;
    assign gnt1_o      = gnt1_q;
    assign res_valid_o = valid_q;
    assign res_id_o    = id_q;
    assign res_s_o     = s_q;
    assign res_cout_o  = cout_q;
    assign res_eq_o    = eq_q;
    assign res_gt_o    = gt_q;
    assign res_lt_o    = lt_q;

endmodule
